// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM output stage.
//   - dt_state_t : dead-time FSM state, fixed 3-bit encoding
//   - DT_W_DEFAULT : default width of dead-time counters and inputs
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int DT_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,   // both outputs off, waiting for enable
        LOW   = 3'd1,   // low-side gate on
        DT_LH = 3'd2,   // blanking before the high side turns on
        HIGH  = 3'd3,   // high-side gate on
        DT_HL = 3'd4    // blanking before the low side turns on
    } dt_state_t;

endpackage

// File: rtl/pwm_deadtime.sv
// -----------------------------------------------------------------------------
// pwm_deadtime
// Complementary gate-drive generator with programmable dead time. Takes the
// single-ended PWM from the core and drives a high-side/low-side pair that is
// never simultaneously active. Pulses or gaps shorter than the dead time are
// swallowed rather than stretched.
//
// Ports:
//   clk_div    in   prescaled PWM clock, rising edge
//   reset      in   asynchronous, active-high
//   enable     in   synchronous run enable; low drives both outputs inactive
//   pwm_in     in   single-ended PWM, clk_div domain
//   dead_rise  in   [DT_W] blanking cycles before out_h asserts
//   dead_fall  in   [DT_W] blanking cycles before out_l asserts
//   pol_h      in   (PWM_DT_POL_EN only) inverts out_h when 1
//   pol_l      in   (PWM_DT_POL_EN only) inverts out_l when 1
//   out_h      out  high-side drive, decoded from registered state
//   out_l      out  low-side drive, decoded from registered state
//   dt_active  out  high while in a blanking state
//
// Build option: define PWM_DT_POL_EN to add per-output polarity inputs.
// Without it the outputs are active-high.
// -----------------------------------------------------------------------------
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DT_W = DT_W_DEFAULT
) (
    input  logic            clk_div,
    input  logic            reset,
    input  logic            enable,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dead_rise,
    input  logic [DT_W-1:0] dead_fall,
`ifdef PWM_DT_POL_EN
    input  logic            pol_h,
    input  logic            pol_l,
`endif
    output logic            out_h,
    output logic            out_l,
    output logic            dt_active
);

    dt_state_t       state, state_nxt;
    logic [DT_W-1:0] cnt, cnt_nxt;
    logic            h_raw, l_raw;

    // State and dead-time counter register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk_div or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and counter logic. The counter is only loaded on entry to a
    // blanking state, so dead-time changes take effect on the next interval.
    // A zero dead time skips the blanking state, which is why the "-1" load
    // can never underflow.
    always_comb begin
        // NOTE: defaults first so no path through the case infers a latch.
        state_nxt = state;
        cnt_nxt   = cnt;

        if (!enable) begin
            // Counter intentionally kept; it is reloaded on the next DT entry.
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = LOW;

                LOW: begin
                    if (pwm_in) begin
                        if (dead_rise == '0) begin
                            state_nxt = HIGH;
                        end else begin
                            state_nxt = DT_LH;
                            cnt_nxt   = dead_rise - DT_W'(1);
                        end
                    end
                end

                DT_LH: begin
                    if (!pwm_in) begin
                        state_nxt = LOW;            // pulse too short: swallow
                    end else if (cnt == '0) begin
                        state_nxt = HIGH;
                    end else begin
                        cnt_nxt = cnt - DT_W'(1);
                    end
                end

                HIGH: begin
                    if (!pwm_in) begin
                        if (dead_fall == '0) begin
                            state_nxt = LOW;
                        end else begin
                            state_nxt = DT_HL;
                            cnt_nxt   = dead_fall - DT_W'(1);
                        end
                    end
                end

                DT_HL: begin
                    if (pwm_in) begin
                        state_nxt = HIGH;           // gap too short: swallow
                    end else if (cnt == '0) begin
                        state_nxt = LOW;
                    end else begin
                        cnt_nxt = cnt - DT_W'(1);
                    end
                end

                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output decode from the registered state only; no input reaches the
    // outputs combinationally, so both sides can never be on together.
    always_comb begin
        h_raw     = 1'b0;
        l_raw     = 1'b0;
        dt_active = 1'b0;
        case (state)
            LOW:          l_raw     = 1'b1;
            HIGH:         h_raw     = 1'b1;
            DT_LH, DT_HL: dt_active = 1'b1;
            default:      ;
        endcase
    end

`ifdef PWM_DT_POL_EN
    // Polarity XOR is the only logic after the state decode; in reset the
    // outputs therefore sit at the polarity values.
    assign out_h = h_raw ^ pol_h;
    assign out_l = l_raw ^ pol_l;
`else
    assign out_h = h_raw;
    assign out_l = l_raw;
`endif

endmodule

// File: tb/tb_pwm_deadtime.sv
// -----------------------------------------------------------------------------
// tb_pwm_deadtime
// Self-checking bench for pwm_deadtime. A behavioural model predicts the
// outputs at every clock edge and pushes them into a scoreboard queue; each
// scenario task pops and compares them on the falling edge, alongside its own
// scenario-specific expectations.
// -----------------------------------------------------------------------------
module tb_pwm_deadtime;

    localparam int DT_W = 8;

    logic            clk_div = 1'b0;
    logic            reset   = 1'b1;
    logic            enable  = 1'b0;
    logic            pwm_in  = 1'b0;
    logic [DT_W-1:0] dead_rise = '0;
    logic [DT_W-1:0] dead_fall = '0;
    logic            out_h, out_l, dt_active;

`ifdef PWM_DT_POL_EN
    logic pol_hv = 1'b1;
    logic pol_lv = 1'b0;
`else
    logic pol_hv = 1'b0;
    logic pol_lv = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    pwm_deadtime #(.DT_W(DT_W)) dut (
        .clk_div   (clk_div),
        .reset     (reset),
        .enable    (enable),
        .pwm_in    (pwm_in),
        .dead_rise (dead_rise),
        .dead_fall (dead_fall),
`ifdef PWM_DT_POL_EN
        .pol_h     (pol_hv),
        .pol_l     (pol_lv),
`endif
        .out_h     (out_h),
        .out_l     (out_l),
        .dt_active (dt_active)
    );

    always #5 clk_div = ~clk_div;

    // ---------------------------------------------------------------- model
    typedef struct packed {
        logic h;
        logic l;
        logic dt;
    } exp_t;

    exp_t sb[$];

    // side: 0 = off, 1 = low side owns the bridge, 2 = high side owns it.
    // While blanking, 'side' still names the previous owner and m_target the
    // side being moved to.
    int m_side   = 0;
    bit m_blank  = 1'b0;
    int m_target = 0;
    int m_left   = 0;

    function automatic void model_reset();
        m_side  = 0;
        m_blank = 1'b0;
    endfunction

    function automatic void model_edge();
        int want;
        int d;
        if (!enable) begin
            m_side  = 0;
            m_blank = 1'b0;
        end else if (m_side == 0) begin
            m_side = 1;
        end else if (m_blank) begin
            want = pwm_in ? 2 : 1;
            if (want != m_target)  m_blank = 1'b0;
            else if (m_left == 0) begin
                m_blank = 1'b0;
                m_side  = m_target;
            end else m_left--;
        end else begin
            want = pwm_in ? 2 : 1;
            if (want != m_side) begin
                d = pwm_in ? int'(dead_rise) : int'(dead_fall);
                if (d == 0) m_side = want;
                else begin
                    m_blank  = 1'b1;
                    m_target = want;
                    m_left   = d - 1;
                end
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.h  = logic'((m_side == 2) && !m_blank) ^ pol_hv;
        e.l  = logic'((m_side == 1) && !m_blank) ^ pol_lv;
        e.dt = m_blank;
        return e;
    endfunction

    // One clock: inputs are already stable; model the edge, push expectation,
    // return on the falling edge where outputs are sampled.
    task automatic tick();
        @(posedge clk_div);
        model_edge();
        sb.push_back(model_out());
        @(negedge clk_div);
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        exp_t e;
        reset  = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk_div);
        total++;
        if (out_h !== pol_hv) begin
            bad++; $display("FAIL reset_out_h got=%b want=%b", out_h, pol_hv);
        end
        total++;
        if (out_l !== pol_lv) begin
            bad++; $display("FAIL reset_out_l got=%b want=%b", out_l, pol_lv);
        end
        total++;
        if (dt_active !== 1'b0) begin
            bad++; $display("FAIL reset_dt got=%b want=0", dt_active);
        end
        model_reset();
        sb.delete();
        reset = 1'b0;
        // enable low: must stay idle
        tick();
        e = sb.pop_front(); total++;
        if ({out_h, out_l, dt_active} !== e) begin
            bad++; $display("FAIL reset_idle got=%b%b%b want=%b", out_h, out_l, dt_active, e);
        end
        enable = 1'b1;
        pwm_in = 1'b1;                    // IDLE -> LOW regardless of pwm_in
        tick();
        e = sb.pop_front(); total++;
        if ({out_h, out_l, dt_active} !== e || (out_l ^ pol_lv) !== 1'b1) begin
            bad++; $display("FAIL reset_to_low got=%b%b%b want=%b", out_h, out_l, dt_active, e);
        end
        pwm_in = 1'b0;
        repeat (2) begin
            tick();
            e = sb.pop_front(); total++;
            if ({out_h, out_l, dt_active} !== e) begin
                bad++; $display("FAIL reset_low got=%b%b%b want=%b", out_h, out_l, dt_active, e);
            end
        end
    endtask

    // dead_rise=3, dead_fall=2, 10 high / 10 low: h runs 7, l runs 8,
    // gaps 3 (L->H) and 2 (H->L).
    task automatic test_main();
        exp_t e;
        int   sym, prev_sym, run, last_side, n_runs, want;
        bit   seen_h;
        dead_rise = 8'd3;
        dead_fall = 8'd2;
        prev_sym = 2; run = 0; last_side = 0; seen_h = 1'b0; n_runs = 0;
        for (int c = 0; c < 60; c++) begin
            pwm_in = ((c % 20) < 10);
            tick();
            e = sb.pop_front(); total++;
            if ({out_h, out_l, dt_active} !== e) begin
                bad++; $display("FAIL main_sb cyc=%0d got=%b%b%b want=%b", c, out_h, out_l, dt_active, e);
            end
            sym = (out_h ^ pol_hv) ? 1 : ((out_l ^ pol_lv) ? 2 : 0);
            if (sym == prev_sym) begin
                run++;
            end else begin
                want = -1;
                if (prev_sym == 1)                                   want = 7;
                else if (prev_sym == 2 && seen_h)                    want = 8;
                else if (prev_sym == 0 && last_side == 1)            want = 2;
                else if (prev_sym == 0 && last_side == 2 && sym == 1) want = 3;
                if (want >= 0) begin
                    n_runs++; total++;
                    if (run !== want) begin
                        bad++; $display("FAIL main_run cyc=%0d kind=%0d got=%0d want=%0d", c, prev_sym, run, want);
                    end
                end
                if (prev_sym == 1) seen_h = 1'b1;
                if (prev_sym != 0) last_side = prev_sym;
                prev_sym = sym;
                run = 1;
            end
        end
        total++;
        if (n_runs !== 11) begin
            bad++; $display("FAIL main_run_count got=%0d want=11", n_runs);
        end
    endtask

    // Zero dead time: out_h is pwm_in delayed one cycle, out_l its complement.
    task automatic test_zero_dt();
        exp_t e;
        logic r;
        dead_rise = '0;
        dead_fall = '0;
        pwm_in    = 1'b0;
        repeat (4) begin
            tick();
            e = sb.pop_front(); total++;
            if ({out_h, out_l, dt_active} !== e) begin
                bad++; $display("FAIL zero_settle got=%b%b%b want=%b", out_h, out_l, dt_active, e);
            end
        end
        for (int c = 0; c < 30; c++) begin
            r = logic'($urandom_range(0, 1));
            pwm_in = r;
            tick();
            e = sb.pop_front(); total++;
            if ({out_h, out_l, dt_active} !== e) begin
                bad++; $display("FAIL zero_sb cyc=%0d got=%b%b%b want=%b", c, out_h, out_l, dt_active, e);
            end
            total++;
            if ((out_h ^ pol_hv) !== r || (out_l ^ pol_lv) !== ~r || dt_active !== 1'b0) begin
                bad++; $display("FAIL zero_delay cyc=%0d got h=%b l=%b dt=%b want h=%b l=%b dt=0",
                                c, out_h ^ pol_hv, out_l ^ pol_lv, dt_active, r, ~r);
            end
        end
    endtask

    // 2-cycle pulse against dead_rise=5 is swallowed.
    task automatic test_swallow();
        exp_t e;
        int   h_cnt, dt_cnt;
        dead_rise = 8'd5;
        dead_fall = 8'd2;
        pwm_in    = 1'b0;
        repeat (3) begin
            tick();
            e = sb.pop_front(); total++;
            if ({out_h, out_l, dt_active} !== e) begin
                bad++; $display("FAIL swallow_pre got=%b%b%b want=%b", out_h, out_l, dt_active, e);
            end
        end
        h_cnt = 0; dt_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            pwm_in = (c < 2);
            tick();
            e = sb.pop_front(); total++;
            if ({out_h, out_l, dt_active} !== e) begin
                bad++; $display("FAIL swallow_sb cyc=%0d got=%b%b%b want=%b", c, out_h, out_l, dt_active, e);
            end
            if ((out_h ^ pol_hv) === 1'b1) h_cnt++;
            if (dt_active === 1'b1) dt_cnt++;
            if (c == 2) begin
                total++;
                if ((out_l ^ pol_lv) !== 1'b1) begin
                    bad++; $display("FAIL swallow_l_back got=%b want=1", out_l ^ pol_lv);
                end
            end
        end
        total++;
        if (h_cnt !== 0) begin
            bad++; $display("FAIL swallow_h got=%0d want=0", h_cnt);
        end
        total++;
        if (dt_cnt !== 2) begin
            bad++; $display("FAIL swallow_dt got=%0d want=2", dt_cnt);
        end
    endtask

    // Drop enable while HIGH, then re-enable: LOW first, then full dead_rise.
    task automatic test_enable_drop();
        exp_t e;
        int   dt_cnt, waited;
        bit   got_h;
        dead_rise = 8'd3;
        dead_fall = 8'd2;
        pwm_in    = 1'b1;
        repeat (6) begin
            tick();
            e = sb.pop_front(); total++;
            if ({out_h, out_l, dt_active} !== e) begin
                bad++; $display("FAIL en_pre got=%b%b%b want=%b", out_h, out_l, dt_active, e);
            end
        end
        total++;
        if ((out_h ^ pol_hv) !== 1'b1) begin
            bad++; $display("FAIL en_high got=%b want=1", out_h ^ pol_hv);
        end
        enable = 1'b0;
        repeat (2) begin
            tick();
            e = sb.pop_front(); total++;
            if ({out_h ^ pol_hv, out_l ^ pol_lv, dt_active} !== 3'b000 || {out_h, out_l, dt_active} !== e) begin
                bad++; $display("FAIL en_off got=%b%b%b want=%b", out_h, out_l, dt_active, e);
            end
        end
        enable = 1'b1;
        tick();
        e = sb.pop_front(); total++;
        if ({out_h ^ pol_hv, out_l ^ pol_lv, dt_active} !== 3'b010 || {out_h, out_l, dt_active} !== e) begin
            bad++; $display("FAIL en_relow got=%b%b%b want=%b", out_h, out_l, dt_active, e);
        end
        dt_cnt = 0; got_h = 1'b0; waited = 0;
        while (!got_h && waited < 10) begin
            tick();
            waited++;
            e = sb.pop_front(); total++;
            if ({out_h, out_l, dt_active} !== e) begin
                bad++; $display("FAIL en_sb got=%b%b%b want=%b", out_h, out_l, dt_active, e);
            end
            if (dt_active === 1'b1) dt_cnt++;
            if ((out_h ^ pol_hv) === 1'b1) got_h = 1'b1;
        end
        total++;
        if (!got_h || dt_cnt !== 3) begin
            bad++; $display("FAIL en_rise got_h=%0b dt=%0d want got_h=1 dt=3", got_h, dt_cnt);
        end
    endtask

    // Toggling faster than dead time: high side stays owner, low never on.
    task automatic test_back_to_back();
        exp_t e;
        int   l_cnt;
        dead_rise = 8'd3;
        dead_fall = 8'd3;
        l_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            pwm_in = (c % 2 == 1);
            tick();
            e = sb.pop_front(); total++;
            if ({out_h, out_l, dt_active} !== e) begin
                bad++; $display("FAIL b2b_sb cyc=%0d got=%b%b%b want=%b", c, out_h, out_l, dt_active, e);
            end
            if ((out_l ^ pol_lv) === 1'b1) l_cnt++;
        end
        total++;
        if (l_cnt !== 0) begin
            bad++; $display("FAIL b2b_low got=%0d want=0", l_cnt);
        end
    endtask

    // Async reset between edges while blanking (DT_HL).
    task automatic test_async_reset();
        exp_t e;
        dead_rise = '0;
        dead_fall = 8'd6;
        pwm_in    = 1'b1;
        repeat (3) begin
            tick();
            e = sb.pop_front(); total++;
            if ({out_h, out_l, dt_active} !== e) begin
                bad++; $display("FAIL ar_pre got=%b%b%b want=%b", out_h, out_l, dt_active, e);
            end
        end
        pwm_in = 1'b0;
        tick();
        e = sb.pop_front(); total++;
        if ({out_h, out_l, dt_active} !== e || dt_active !== 1'b1) begin
            bad++; $display("FAIL ar_in_dt got=%b%b%b want=%b", out_h, out_l, dt_active, e);
        end
        #1 reset = 1'b1;
        #1;
        total++;
        if (out_h !== pol_hv || out_l !== pol_lv || dt_active !== 1'b0) begin
            bad++; $display("FAIL ar_immediate got=%b%b%b want=%b%b0", out_h, out_l, dt_active, pol_hv, pol_lv);
        end
        model_reset();
        @(posedge clk_div);
        @(negedge clk_div);
        reset = 1'b0;
        tick();
        e = sb.pop_front(); total++;
        if ({out_h ^ pol_hv, out_l ^ pol_lv, dt_active} !== 3'b010 || {out_h, out_l, dt_active} !== e) begin
            bad++; $display("FAIL ar_relow got=%b%b%b want=%b", out_h, out_l, dt_active, e);
        end
    endtask

    // Random run lengths, dead times and occasional enable drops.
    task automatic test_random();
        exp_t e;
        int   run_left;
        run_left = 0;
        for (int c = 0; c < 400; c++) begin
            if (run_left == 0) begin
                pwm_in   = ~pwm_in;
                run_left = $urandom_range(1, 8);
            end
            run_left--;
            if (c % 25 == 0) begin
                dead_rise = DT_W'($urandom_range(0, 4));
                dead_fall = DT_W'($urandom_range(0, 4));
            end
            enable = ($urandom_range(0, 99) >= 3);
            tick();
            e = sb.pop_front(); total++;
            if ({out_h, out_l, dt_active} !== e) begin
                bad++; $display("FAIL rand_sb cyc=%0d got=%b%b%b want=%b", c, out_h, out_l, dt_active, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_main();
        test_zero_dt();
        test_swallow();
        test_enable_drop();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
